// File: rtl/axis_sample_streamer_pkg.sv
// Shared defaults and FSM state encoding for the sample streamer.
package axis_sample_streamer_pkg;

  localparam int dataWidth       = 16;
  localparam int numWeightLayer1 = 784;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } state_t;

endpackage

// File: rtl/axis_sample_streamer_sample_buffer.sv
// Sample store: single write port, registered (synchronous) read port.
// Contents are not reset; the streamer replays whatever was last written.
module sample_buffer
  import axis_sample_streamer_pkg::*;
#(
  parameter int DATA_WIDTH  = dataWidth,
  parameter int NUM_SAMPLES = numWeightLayer1,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                  s_axi_aclk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [NUM_SAMPLES];

  // Write on strobe; read is always registered so data lags address by one cycle.
  always_ff @(posedge s_axi_aclk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/axis_sample_streamer.sv
// Buffers one input vector of NUM_SAMPLES samples and streams it out over
// AXI-Stream on request. Optional macro STREAMER_LOOP_EN adds the loop_en
// input, which wraps the pass back to sample 0 without a bubble.
//
// state  | meaning
// IDLE   | accepting writes / clear; waiting for start with a full buffer
// PRIME  | one-cycle synchronous read of sample 0
// STREAM | presenting samples; m_axis_valid high
module axis_sample_streamer
  import axis_sample_streamer_pkg::*;
#(
  parameter int DATA_WIDTH  = dataWidth,
  parameter int NUM_SAMPLES = numWeightLayer1,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                  s_axi_aclk,
  input  logic                  reset,
`ifdef STREAMER_LOOP_EN
  input  logic                  loop_en,
`endif
  input  logic                  wr_en,
  input  logic [31:0]           wr_data,
  input  logic                  clear_buf,
  input  logic                  start,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_valid,
  input  logic                  m_axis_ready,
  output logic                  m_axis_last,
  output logic                  buf_full,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_overflow
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(NUM_SAMPLES);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_SAMPLES - 1);

  state_t           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             buf_we;
  logic             xfer;

  if (DATA_WIDTH < 32) begin : g_unused
    logic unused_wr_bits;
    assign unused_wr_bits = ^wr_data[31:DATA_WIDTH];
  end

  assign buf_full     = (wr_ptr_q == FULL_CNT);
  assign m_axis_valid = (state_q == STREAM);
  assign m_axis_last  = m_axis_valid && (rd_ptr_q == LAST_IDX);
  assign xfer         = m_axis_valid && m_axis_ready;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign wr_overflow  = ovf_q;

  // Read address tracks the next pointer, so the sample behind the current
  // beat is already fetched when it transfers (no bubbles, stable on stall).
  sample_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_SAMPLES(NUM_SAMPLES),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_buf (
    .s_axi_aclk(s_axi_aclk),
    .we        (buf_we),
    .waddr     (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata     (wr_data[DATA_WIDTH-1:0]),
    .raddr     (rd_ptr_d[ADDR_WIDTH-1:0]),
    .rdata     (m_axis_data)
  );

  // State and pointer registers.
  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
    end
  end

  // Next-state, pointer updates and buffer write enable.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;
    buf_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_buf) begin
          wr_ptr_d = '0;
          ovf_d    = 1'b0;
        end else if (wr_en) begin
          if (buf_full) begin
            ovf_d = 1'b1;
          end else begin
            buf_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
        if (start && buf_full) begin
          state_d  = PRIME;
          rd_ptr_d = '0;
        end
      end
      PRIME: state_d = STREAM;
      STREAM: begin
        if (xfer) begin
          if (rd_ptr_q == LAST_IDX) begin
            done_d = 1'b1;
`ifdef STREAMER_LOOP_EN
            if (loop_en) rd_ptr_d = '0;
            else         state_d  = IDLE;
`else
            state_d = IDLE;
`endif
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_sample_streamer.sv
// Randomized bench for axis_sample_streamer (NUM_SAMPLES=4, DATA_WIDTH=16)
// against a vector/pointer model of the buffer. Define STREAMER_LOOP_EN to
// also exercise looping passes.
module tb_axis_sample_streamer;

  localparam int N  = 4;
  localparam int DW = 16;

  logic          s_axi_aclk = 1'b0;
  logic          reset;
  logic          loop_en;
  logic          wr_en;
  logic [31:0]   wr_data;
  logic          clear_buf;
  logic          start;
  logic [DW-1:0] m_axis_data;
  logic          m_axis_valid;
  logic          m_axis_ready;
  logic          m_axis_last;
  logic          buf_full;
  logic          busy;
  logic          done;
  logic          wr_overflow;

  axis_sample_streamer #(
    .DATA_WIDTH (DW),
    .NUM_SAMPLES(N),
    .ADDR_WIDTH (2)
  ) dut (
    .s_axi_aclk  (s_axi_aclk),
    .reset       (reset),
`ifdef STREAMER_LOOP_EN
    .loop_en     (loop_en),
`endif
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .clear_buf   (clear_buf),
    .start       (start),
    .m_axis_data (m_axis_data),
    .m_axis_valid(m_axis_valid),
    .m_axis_ready(m_axis_ready),
    .m_axis_last (m_axis_last),
    .buf_full    (buf_full),
    .busy        (busy),
    .done        (done),
    .wr_overflow (wr_overflow)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: the stored vector, the write count and the sticky overflow flag.
  logic [DW-1:0] mdl_mem [N];
  int            mdl_wptr = 0;
  logic          mdl_ovf  = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge s_axi_aclk);
    #1;
  endtask

  task automatic do_write(input logic [DW-1:0] v);
    wr_en   = 1'b1;
    wr_data = {16'($urandom), v};
    tick();
    wr_en = 1'b0;
    if (mdl_wptr == N) mdl_ovf = 1'b1;
    else begin
      mdl_mem[mdl_wptr] = v;
      mdl_wptr++;
    end
    check("wr_full", 32'(buf_full), 32'(mdl_wptr == N));
    check("wr_ovf", 32'(wr_overflow), 32'(mdl_ovf));
  endtask

  task automatic do_clear(input logic with_wr);
    clear_buf = 1'b1;
    wr_en     = with_wr;
    wr_data   = $urandom;
    tick();
    clear_buf = 1'b0;
    wr_en     = 1'b0;
    mdl_wptr  = 0;
    mdl_ovf   = 1'b0;
    check("clr_full", 32'(buf_full), 32'(0));
    check("clr_ovf", 32'(wr_overflow), 32'(0));
  endtask

  function automatic logic pick_ready(input int mode, input int k);
    case (mode)
      0:       return 1'b1;
      1:       return (k % 4 == 0) || (k % 4 == 3);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Start a pass and consume `passes` passes of N beats. mode picks the ready
  // pattern; noise drives wr_en/clear_buf/start randomly while streaming;
  // reset_at > 0 asserts reset after that many beats.
  task automatic run_pass(input int mode, input bit noise, input int reset_at, input int passes);
    int   idx = 0, beats = 0, cyc = 0, k = 0, total;
    logic last_prev = 1'b0;
    logic rdy;
    total = passes * N;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("prime_valid", 32'(m_axis_valid), 32'(0));
    check("prime_busy", 32'(busy), 32'(1));
    tick();
    check("valid_rise", 32'(m_axis_valid), 32'(1));
    while (beats < total) begin
      if (cyc >= 200) begin
        check("timeout", 32'(0), 32'(1));
        break;
      end
      check("done_mid", 32'(done), 32'(last_prev));
      if (reset_at > 0 && beats == reset_at) begin
        reset        = 1'b1;
        m_axis_ready = 1'b1;
        wr_en = 1'b0; clear_buf = 1'b0; start = 1'b0;
        tick();
        reset = 1'b0;
        mdl_wptr = 0;
        mdl_ovf  = 1'b0;
        check("rst_valid", 32'(m_axis_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_full", 32'(buf_full), 32'(0));
        tick();
        check("rst_valid2", 32'(m_axis_valid), 32'(0));
        return;
      end
      rdy          = pick_ready(mode, k);
      k++;
      m_axis_ready = rdy;
      loop_en      = (beats < total - N);
      if (noise) begin
        wr_en     = 1'($urandom_range(0, 1));
        wr_data   = $urandom;
        clear_buf = 1'($urandom_range(0, 1));
        start     = 1'($urandom_range(0, 1));
      end
      @(negedge s_axi_aclk);
      check("valid_hi", 32'(m_axis_valid), 32'(1));
      check("data", 32'(m_axis_data), 32'(mdl_mem[idx]));
      check("last", 32'(m_axis_last), 32'(idx == N - 1));
      last_prev = rdy && (idx == N - 1);
      if (rdy) begin
        beats++;
        idx = (idx + 1) % N;
      end
      @(posedge s_axi_aclk);
      #1;
      cyc++;
    end
    wr_en = 1'b0; clear_buf = 1'b0; start = 1'b0;
    m_axis_ready = 1'b0;
    loop_en      = 1'b0;
    check("done_end", 32'(done), 32'(1));
    check("valid_end", 32'(m_axis_valid), 32'(0));
    check("busy_end", 32'(busy), 32'(0));
    tick();
    check("done_once", 32'(done), 32'(0));
  endtask

  initial begin
    reset = 1'b1; loop_en = 1'b0; wr_en = 1'b0; wr_data = '0;
    clear_buf = 1'b0; start = 1'b0; m_axis_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst_valid0", 32'(m_axis_valid), 32'(0));
    check("rst_last0", 32'(m_axis_last), 32'(0));
    check("rst_done0", 32'(done), 32'(0));
    check("rst_busy0", 32'(busy), 32'(0));
    check("rst_full0", 32'(buf_full), 32'(0));
    check("rst_ovf0", 32'(wr_overflow), 32'(0));

    // Directed vector, ready held high, then replay with a stalling sink.
    do_write(16'h0011); do_write(16'h0022); do_write(16'h0033); do_write(16'h0044);
    run_pass(0, 1'b0, 0, 1);
    run_pass(1, 1'b0, 0, 1);

    // Start with a partial buffer is ignored; overflow after full; clear.
    do_clear(1'b0);
    for (int i = 0; i < 3; i++) do_write(16'($urandom));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_partial_busy", 32'(busy), 32'(0));
    tick();
    check("start_partial_busy2", 32'(busy), 32'(0));
    check("start_partial_valid", 32'(m_axis_valid), 32'(0));
    do_write(16'($urandom));
    do_write(16'($urandom));
    check("ovf_set", 32'(wr_overflow), 32'(1));
    // Writes/clears/starts during streaming must be ignored.
    run_pass(2, 1'b1, 0, 1);
    check("ovf_kept", 32'(wr_overflow), 32'(1));
    check("full_kept", 32'(buf_full), 32'(1));
    run_pass(0, 1'b0, 0, 1);
    do_clear(1'b0);

    // clear_buf wins over a simultaneous write: exactly 4 writes refill.
    do_write(16'($urandom));
    do_clear(1'b1);
    for (int i = 0; i < N; i++) do_write(16'($urandom));
    run_pass(2, 1'b0, 0, 1);

    // Reset after beat 2, then reload and stream a full pass from index 0.
    run_pass(0, 1'b0, 2, 1);
    check("rst_last", 32'(m_axis_last), 32'(0));
    for (int i = 0; i < N; i++) do_write(16'($urandom));
    run_pass(0, 1'b0, 0, 1);

`ifdef STREAMER_LOOP_EN
    do_clear(1'b0);
    do_write(16'h0011); do_write(16'h0022); do_write(16'h0033); do_write(16'h0044);
    run_pass(0, 1'b0, 0, 2);
    run_pass(2, 1'b0, 0, 3);
`endif

    // Random vectors with random sink backpressure.
    for (int r = 0; r < 4; r++) begin
      do_clear(1'b0);
      for (int i = 0; i < N; i++) do_write(16'($urandom));
      run_pass(2, r[0], 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
